count_seq_ctrl: RTL and testbench

- Sequential counter stage that wraps the team's combinational 16-bit load/clear counter next-state logic.
- Holds the count register, a reload register and a one-shot/auto-reload control FSM.
- Reports terminal-count events to a downstream consumer over a valid/ready handshake, with buffered pending events.
- Sits directly downstream of the next-state logic and upstream of the event-consuming sequencer.

---
 rtl/count_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_count_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// Counter stage: count/reload registers, one-shot/auto-reload FSM, buffered terminal events.
// Optional macro COUNT_UPDOWN_EN adds an 'up' input for up-counting toward all-ones.
module count_seq_ctrl #(
    parameter int WIDTH     = 16,
    parameter int EVT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             auto_reload,
`ifdef COUNT_UPDOWN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_overflow
);

    localparam int PW = $clog2(EVT_DEPTH + 1);
    localparam logic [PW-1:0] PMAX = PW'(EVT_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    pend;
    logic [PW-1:0]    pend_nxt;
    logic             ovf_set;
    logic             dir_up;
    logic             at_term;
    logic             step;
    logic             gen;
    logic             hs;

`ifdef COUNT_UPDOWN_EN
    assign dir_up = up;
`else
    assign dir_up = 1'b0;
`endif

    assign at_term   = dir_up ? (count == '1) : (count == '0);
    assign step      = (state == S_RUN) & en & ~load & ~clr;
    assign gen       = step & at_term;
    assign hs        = evt_valid & evt_ready;

    assign zero      = (count == '0);
    assign busy      = (state == S_RUN);
    assign evt_valid = (pend != '0);

    // Next count/state: load wins over counting; terminal either reloads or halts.
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (load) begin
            count_nxt = din;
            state_nxt = S_RUN;
        end else if (step) begin
            if (at_term) begin
                if (auto_reload) begin
                    count_nxt = reload;
                end else begin
                    state_nxt = S_DONE;
                end
            end else if (dir_up) begin
                count_nxt = count + 1'b1;
            end else begin
                count_nxt = count - 1'b1;
            end
        end
    end

    // Pending-event counter: simultaneous generate and accept cancel out.
    always_comb begin
        pend_nxt = pend;
        ovf_set  = 1'b0;
        if (gen && !hs) begin
            if (pend == PMAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_nxt = pend + 1'b1;
            end
        end else if (hs && !gen) begin
            pend_nxt = pend - 1'b1;
        end
    end

    // Count, reload and FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            reload <= '0;
            state  <= S_IDLE;
        end else if (clr) begin
            count  <= '0;
            reload <= '0;
            state  <= S_IDLE;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
            if (load) begin
                reload <= din;
            end
        end
    end

    // Event store and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= '0;
            evt_overflow <= 1'b0;
        end else if (clr) begin
            pend         <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (ovf_set) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Testbench for count_seq_ctrl: vector table, corner sequences, random vs model.
// Uses the default build (COUNT_UPDOWN_EN undefined), EVT_DEPTH = 4.
module tb_count_seq_ctrl;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr, load, en, auto_reload, evt_ready;
    logic [W-1:0] din;
    logic [W-1:0] count;
    logic         zero, busy, evt_valid, evt_overflow;

    int total = 0;
    int bad   = 0;

    count_seq_ctrl #(.WIDTH(W), .EVT_DEPTH(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .load(load),
        .en(en),
        .din(din),
        .auto_reload(auto_reload),
        .count(count),
        .zero(zero),
        .busy(busy),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         c_clr;
        logic         c_load;
        logic         c_en;
        logic [W-1:0] c_din;
        logic         c_ar;
        logic         c_rdy;
        logic [W-1:0] x_cnt;
        logic         x_zero;
        logic         x_busy;
        logic         x_valid;
        logic         x_ovf;
    } vec_t;

    vec_t tv[15];

    // reference model state
    int m_cnt, m_rel, m_pend;
    bit m_run, m_ovf;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int c, input bit z,
                           input bit b, input bit v, input bit o);
        chk({nm, ".count"}, 32'(count), 32'(c));
        chk({nm, ".zero"}, 32'(zero), 32'(z));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".valid"}, 32'(evt_valid), 32'(v));
        chk({nm, ".ovf"}, 32'(evt_overflow), 32'(o));
    endtask

    task automatic model_step();
        bit hs;
        bit ev;
        if (clr) begin
            m_cnt = 0; m_rel = 0; m_pend = 0; m_run = 0; m_ovf = 0;
            return;
        end
        hs = (m_pend > 0) && evt_ready;
        ev = 0;
        if (load) begin
            m_cnt = int'(din);
            m_rel = int'(din);
            m_run = 1;
        end else if (m_run && en) begin
            if (m_cnt == 0) begin
                ev = 1;
                if (auto_reload) m_cnt = m_rel;
                else m_run = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (ev && !hs) begin
            if (m_pend == D) m_ovf = 1;
            else m_pend++;
        end else if (hs && !ev) begin
            m_pend--;
        end
    endtask

    initial begin
        tv[0]  = '{0, 1, 1, 16'd3, 0, 0, 16'd3, 0, 1, 0, 0};
        tv[1]  = '{0, 0, 1, 16'd0, 0, 0, 16'd2, 0, 1, 0, 0};
        tv[2]  = '{0, 0, 1, 16'd0, 0, 0, 16'd1, 0, 1, 0, 0};
        tv[3]  = '{0, 0, 1, 16'd0, 0, 0, 16'd0, 1, 1, 0, 0};
        tv[4]  = '{0, 0, 1, 16'd0, 0, 0, 16'd0, 1, 0, 1, 0};
        tv[5]  = '{0, 0, 1, 16'd0, 0, 1, 16'd0, 1, 0, 0, 0};
        tv[6]  = '{0, 0, 1, 16'd0, 0, 0, 16'd0, 1, 0, 0, 0};
        tv[7]  = '{0, 1, 0, 16'd2, 1, 0, 16'd2, 0, 1, 0, 0};
        tv[8]  = '{0, 0, 1, 16'd0, 1, 1, 16'd1, 0, 1, 0, 0};
        tv[9]  = '{0, 0, 1, 16'd0, 1, 1, 16'd0, 1, 1, 0, 0};
        tv[10] = '{0, 0, 1, 16'd0, 1, 0, 16'd2, 0, 1, 1, 0};
        tv[11] = '{0, 0, 1, 16'd0, 1, 1, 16'd1, 0, 1, 0, 0};
        tv[12] = '{1, 1, 1, 16'd5, 0, 0, 16'd0, 1, 0, 0, 0};
        tv[13] = '{0, 1, 1, 16'd5, 0, 0, 16'd5, 0, 1, 0, 0};
        tv[14] = '{0, 0, 1, 16'd0, 0, 0, 16'd4, 0, 1, 0, 0};

        rst_n = 1'b0;
        clr = 0; load = 0; en = 0; din = '0; auto_reload = 0; evt_ready = 0;
        #12;
        chk_all("reset", 0, 1, 0, 0, 0);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 15; i++) begin
            clr = tv[i].c_clr; load = tv[i].c_load; en = tv[i].c_en;
            din = tv[i].c_din; auto_reload = tv[i].c_ar;
            evt_ready = tv[i].c_rdy;
            step();
            chk_all($sformatf("tv%0d", i), int'(tv[i].x_cnt), tv[i].x_zero,
                    tv[i].x_busy, tv[i].x_valid, tv[i].x_ovf);
        end

        // saturation: load 0 with auto-reload, six events, no consumer
        clr = 0; load = 1; en = 0; din = '0; auto_reload = 1; evt_ready = 0;
        step();
        chk("sat.load.busy", 32'(busy), 32'd1);
        load = 0; en = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("sat.ev%0d.valid", i), 32'(evt_valid), 32'd1);
            chk($sformatf("sat.ev%0d.ovf", i), 32'(evt_overflow),
                (i >= 5) ? 32'd1 : 32'd0);
        end
        // full store: event plus accept in the same cycle keeps pend at 4
        evt_ready = 1;
        step();
        chk("same.valid", 32'(evt_valid), 32'd1);
        chk("same.ovf", 32'(evt_overflow), 32'd1);
        en = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("drain%0d.valid", k), 32'(evt_valid),
                (k < 4) ? 32'd1 : 32'd0);
        end
        evt_ready = 0; clr = 1;
        step();
        chk("clr.ovf", 32'(evt_overflow), 32'd0);
        clr = 0;

        // asynchronous reset mid-count with an event pending
        load = 1; din = '0; auto_reload = 1;
        step();
        load = 0; en = 1;
        step();
        load = 1; en = 0; din = 16'd7;
        step();
        chk("pre.count", 32'(count), 32'd7);
        chk("pre.valid", 32'(evt_valid), 32'd1);
        load = 0;
        #2 rst_n = 1'b0;
        #1;
        chk_all("async", 0, 1, 0, 0, 0);
        #2 rst_n = 1'b1;
        load = 1; din = 16'd3;
        step();
        chk("post.count", 32'(count), 32'd3);
        chk("post.busy", 32'(busy), 32'd1);

        // random stimulus against reference model
        load = 0; clr = 1;
        model_step();
        step();
        for (int n = 0; n < 400; n++) begin
            clr         = ($urandom % 40) == 0;
            load        = ($urandom % 8) == 0;
            en          = ($urandom % 4) != 0;
            din         = W'($urandom % 5);
            auto_reload = $urandom % 2;
            evt_ready   = ($urandom % 3) == 0;
            model_step();
            step();
            chk_all($sformatf("rnd%0d", n), m_cnt, (m_cnt == 0), m_run,
                    (m_pend != 0), m_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
